// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data_mem_bank data memory.
//   dmem_state_t : controller states (IDLE, BUSY, RESP)
//   BE_W/OFF_W/IDX_W : lane/offset/index widths for the default 32-bit x 1024 build
//   byte_parity  : even-parity bit for one byte lane
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam int DATA_W_DFLT = 32;
  localparam int DEPTH_DFLT  = 1024;
  localparam int BE_W        = DATA_W_DFLT / 8;
  localparam int OFF_W       = $clog2(BE_W);
  localparam int IDX_W       = $clog2(DEPTH_DFLT);

  // Bit that makes the byte plus the bit hold an even number of ones.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/dmem_rd_pipe.sv
// dmem_rd_pipe: LAT-deep valid/data/err shift register carrying read
// responses from the accept edge to the response cycle.
//   clk, reset          : clock, synchronous active-high reset (clears valids)
//   in_valid/data/err   : read launched at this edge
//   out_valid/data/err  : read visible LAT cycles after launch
module dmem_rd_pipe #(
  parameter int W   = 32,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         in_err,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_err
);

  logic [LAT-1:0] vld_d, vld_q;
  logic [LAT-1:0] err_d, err_q;
  logic [W-1:0]   dat_d [LAT];
  logic [W-1:0]   dat_q [LAT];

  always_comb begin
    vld_d[0] = in_valid;
    err_d[0] = in_err;
    dat_d[0] = in_data;
    for (int i = 1; i < LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      err_d[i] = err_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
  end

  // Only the valids are reset: a dropped read must never surface.
  always_ff @(posedge clk) begin
    if (reset) vld_q <= '0;
    else       vld_q <= vld_d;
  end

  always_ff @(posedge clk) begin
    err_q <= err_d;
    for (int i = 0; i < LAT; i++) dat_q[i] <= dat_d[i];
  end

  assign out_valid = vld_q[LAT-1];
  assign out_data  = dat_q[LAT-1];
  assign out_err   = err_q[LAT-1];

endmodule

// File: rtl/data_mem_bank.sv
// data_mem_bank: word-organised MEM-stage data memory with a valid/ready
// request channel, byte strobes, RD_LAT-cycle reads and 1-cycle writes.
//   clk, reset         : clock, synchronous active-high reset
//   req_valid/ready    : request handshake (accept = valid && ready)
//   req_we/addr/wdata/be : request fields, captured at accept
//   resp_valid         : one-cycle response pulse
//   resp_rdata/err     : response payload, held while resp_valid is low
// Optional build macro DMEM_PARITY_EN adds per-lane even parity storage and
// the test-only inject_perr input.
//
// state | meaning
// IDLE  | ready, nothing pending
// BUSY  | multi-cycle read in flight, down-counter running, not ready
// RESP  | response on the outputs, ready for a back-to-back request
module data_mem_bank
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 1      // 1..4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
`ifdef DMEM_PARITY_EN
  input  logic                inject_perr,
`endif
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err
);

  localparam int LANES = DATA_W / 8;
  localparam int OFFB  = $clog2(LANES);
  localparam int IDXB  = $clog2(DEPTH);
  localparam int CNT_W = 3;

  dmem_state_t      state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             mis, oor, err, acc;
  logic [IDXB-1:0]  idx;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_word;
  logic             par_err;

  logic              pipe_vld, pipe_err;
  logic [DATA_W-1:0] pipe_data;
  logic              fast_err_d, fast_err_q;
  logic [DATA_W-1:0] hold_rdata_d, hold_rdata_q, cur_rdata;
  logic              hold_err_d, hold_err_q, cur_err;

  // ---------------- address checks ----------------
  generate
    if (OFFB > 0) begin : g_mis
      assign mis = |req_addr[OFFB-1:0];
    end else begin : g_no_mis
      assign mis = 1'b0;
    end
    if (ADDR_W > IDXB + OFFB) begin : g_oor
      assign oor = |req_addr[ADDR_W-1:IDXB+OFFB];
    end else begin : g_no_oor
      assign oor = 1'b0;
    end
  endgenerate

  assign idx = req_addr[IDXB+OFFB-1:OFFB];
  assign err = mis | oor;

  // A request coinciding with reset is discarded, including its write.
  assign req_ready = (state_q != BUSY);
  assign acc       = req_valid && req_ready && !reset;

  // ---------------- controller ----------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, RESP: begin
        if (acc) begin
          if (!req_we && !err && (RD_LAT > 1)) begin
            state_d = BUSY;
            cnt_d   = CNT_W'(RD_LAT - 1);
          end else begin
            state_d = RESP;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------- storage ----------------
  always_ff @(posedge clk) begin
    if (acc && req_we && !err) begin
      for (int i = 0; i < LANES; i++) begin
        if (req_be[i]) mem_q[idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  assign rd_word = mem_q[idx];

`ifdef DMEM_PARITY_EN
  logic [LANES-1:0] par_q [DEPTH];
  logic [LANES-1:0] par_calc;

  always_ff @(posedge clk) begin
    if (acc && req_we && !err) begin
      for (int i = 0; i < LANES; i++) begin
        if (req_be[i]) par_q[idx][i] <= byte_parity(req_wdata[8*i +: 8]) ^ inject_perr;
      end
    end
  end

  always_comb begin
    par_calc = '0;
    for (int i = 0; i < LANES; i++) par_calc[i] = byte_parity(rd_word[8*i +: 8]);
  end

  assign par_err = |(par_calc ^ par_q[idx]);
`else
  assign par_err = 1'b0;
`endif

  // ---------------- response paths ----------------
  // Good reads travel the RD_LAT pipe; writes and errors answer next cycle.
  dmem_rd_pipe #(
    .W   (DATA_W),
    .LAT (RD_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (acc && !req_we && !err),
    .in_data   (rd_word),
    .in_err    (par_err),
    .out_valid (pipe_vld),
    .out_data  (pipe_data),
    .out_err   (pipe_err)
  );

  assign fast_err_d = acc && err;

  assign resp_valid = (state_q == RESP);
  assign cur_rdata  = pipe_vld ? pipe_data : '0;
  assign cur_err    = pipe_vld ? pipe_err  : fast_err_q;

  assign hold_rdata_d = resp_valid ? cur_rdata : hold_rdata_q;
  assign hold_err_d   = resp_valid ? cur_err   : hold_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fast_err_q   <= 1'b0;
      hold_rdata_q <= '0;
      hold_err_q   <= 1'b0;
    end else begin
      fast_err_q   <= fast_err_d;
      hold_rdata_q <= hold_rdata_d;
      hold_err_q   <= hold_err_d;
    end
  end

  assign resp_rdata = resp_valid ? cur_rdata : hold_rdata_q;
  assign resp_err   = resp_valid ? cur_err   : hold_err_q;

endmodule

// File: tb/tb_data_mem_bank.sv
module tb_data_mem_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_we    [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic [3:0]  req_be    [3];
  logic        resp_valid[3];
  logic [31:0] resp_rdata[3];
  logic        resp_err  [3];
`ifdef DMEM_PARITY_EN
  logic        inject_perr[3];
`endif

  always #5 clk = ~clk;

  // Instance 0: RD_LAT=1, instance 1: RD_LAT=3, instance 2: RD_LAT=4
  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      data_mem_bank #(
        .DATA_W(32), .ADDR_W(32), .DEPTH(1024),
        .RD_LAT((g == 0) ? 1 : ((g == 1) ? 3 : 4))
      ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid[g]),
        .req_ready  (req_ready[g]),
        .req_we     (req_we[g]),
        .req_addr   (req_addr[g]),
        .req_wdata  (req_wdata[g]),
        .req_be     (req_be[g]),
`ifdef DMEM_PARITY_EN
        .inject_perr(inject_perr[g]),
`endif
        .resp_valid (resp_valid[g]),
        .resp_rdata (resp_rdata[g]),
        .resp_err   (resp_err[g])
      );
    end
  endgenerate

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
  endfunction

  // Reference model: plain word array per instance, rules applied directly.
  logic [31:0] mdl [3][1024];

  function automatic void model_req(input int k, input bit we, input logic [31:0] addr,
                                    input logic [31:0] wdata, input logic [3:0] be,
                                    output logic [31:0] er, output logic ee, output int el);
    bit bad;
    int w;
    bad = (addr % 4 != 0) || (addr >= 32'h1000);
    w   = int'(addr / 4);
    if (bad) begin
      er = 0; ee = 1; el = 1;
    end else if (we) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mdl[k][w][8*i +: 8] = wdata[8*i +: 8];
      er = 0; ee = 0; el = 1;
    end else begin
      er = mdl[k][w]; ee = 0; el = lat_of(k);
    end
  endfunction

  // Issue one request on instance k at a negedge, wait for its response.
  task automatic xact(input int k, input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be,
                      output logic [31:0] rdata, output logic err, output int lat);
    int w;
    w = 0;
    while (req_ready[k] !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    check("ready_wait", 32'(w < 20), 32'd1);
    req_valid[k] = 1'b1; req_we[k] = we; req_addr[k] = addr;
    req_wdata[k] = wdata; req_be[k] = be;
    @(negedge clk);
    req_valid[k] = 1'b0;
    lat = 1;
    while (resp_valid[k] !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    rdata = resp_rdata[k];
    err   = resp_err[k];
    @(negedge clk);
    check("pulse_end", 32'(resp_valid[k]), 32'd0);
  endtask

  task automatic checked_req(input int k, input bit we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be);
    logic [31:0] er, ar;
    logic ee, ae;
    int el, al;
    model_req(k, we, addr, wdata, be, er, ee, el);
    xact(k, we, addr, wdata, be, ar, ae, al);
    check($sformatf("rnd_rdata k%0d a%h", k, addr), ar, er);
    check($sformatf("rnd_err k%0d a%h", k, addr), 32'(ae), 32'(ee));
    check($sformatf("rnd_lat k%0d a%h", k, addr), 32'(al), 32'(el));
  endtask

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[$];
    logic [31:0] ar, er;
    logic        ae, ee;
    int          al, el, cnt;
    logic [31:0] got[$];
    bit          rdy[6];

    vecs.push_back('{1, 32'h10,       32'hDEADBEEF, 4'hF, 32'h0,        0});
    vecs.push_back('{0, 32'h10,       32'h0,        4'h0, 32'hDEADBEEF, 0});
    vecs.push_back('{1, 32'h10,       32'h000000AA, 4'h1, 32'h0,        0});
    vecs.push_back('{0, 32'h10,       32'h0,        4'h0, 32'hDEADBEAA, 0});
    vecs.push_back('{0, 32'h13,       32'h0,        4'h0, 32'h0,        1});
    vecs.push_back('{1, 32'h0,        32'h11223344, 4'hF, 32'h0,        0});
    vecs.push_back('{0, 32'h1000,     32'h0,        4'h0, 32'h0,        1});
    vecs.push_back('{1, 32'h1000,     32'hFFFFFFFF, 4'hF, 32'h0,        1});
    vecs.push_back('{0, 32'h0,        32'h0,        4'h0, 32'h11223344, 0});
    vecs.push_back('{1, 32'h11,       32'hFFFFFFFF, 4'hF, 32'h0,        1});
    vecs.push_back('{1, 32'h10,       32'hCAFE0000, 4'h0, 32'h0,        0});
    vecs.push_back('{0, 32'h10,       32'h0,        4'h0, 32'hDEADBEAA, 0});
    vecs.push_back('{1, 32'h10,       32'h55667788, 4'hA, 32'h0,        0});
    vecs.push_back('{0, 32'h10,       32'h0,        4'h0, 32'h55AD77AA, 0});
    vecs.push_back('{0, 32'h80000000, 32'h0,        4'h0, 32'h0,        1});
    vecs.push_back('{1, 32'hFFC,      32'h0BADF00D, 4'hF, 32'h0,        0});
    vecs.push_back('{0, 32'hFFC,      32'h0,        4'h0, 32'h0BADF00D, 0});

    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_valid[k] = 0; req_we[k] = 0; req_addr[k] = 0; req_wdata[k] = 0; req_be[k] = 0;
`ifdef DMEM_PARITY_EN
      inject_perr[k] = 0;
`endif
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_ready k%0d", k), 32'(req_ready[k]), 32'd1);
      check($sformatf("rst_valid k%0d", k), 32'(resp_valid[k]), 32'd0);
      check($sformatf("rst_rdata k%0d", k), resp_rdata[k], 32'h0);
      check($sformatf("rst_err k%0d", k), 32'(resp_err[k]), 32'd0);
    end

    // Table vectors on RD_LAT=1 and RD_LAT=3 instances
    for (int k = 0; k < 2; k++) begin
      for (int v = 0; v < vecs.size(); v++) begin
        model_req(k, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].be, er, ee, el);
        xact(k, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].be, ar, ae, al);
        check($sformatf("vec%0d_rdata k%0d", v, k), ar, vecs[v].exp_rdata);
        check($sformatf("vec%0d_err k%0d", v, k), 32'(ae), 32'(vecs[v].exp_err));
        check($sformatf("vec%0d_lat k%0d", v, k), 32'(al),
              32'((vecs[v].we || vecs[v].exp_err) ? 1 : lat_of(k)));
      end
    end

    // Back-to-back write then read of the same word (write-first)
    model_req(0, 1, 32'h18, 32'hA5A5A5A5, 4'hF, er, ee, el);
    req_valid[0] = 1; req_we[0] = 1; req_addr[0] = 32'h18;
    req_wdata[0] = 32'hA5A5A5A5; req_be[0] = 4'hF;
    @(negedge clk);
    check("b2b_ready", 32'(req_ready[0]), 32'd1);
    check("b2b_wr_valid", 32'(resp_valid[0]), 32'd1);
    check("b2b_wr_err", 32'(resp_err[0]), 32'd0);
    req_we[0] = 0;
    @(negedge clk);
    check("b2b_rd_valid", 32'(resp_valid[0]), 32'd1);
    check("b2b_rd_data", resp_rdata[0], 32'hA5A5A5A5);
    req_valid[0] = 0;
    @(negedge clk);
    check("b2b_idle", 32'(resp_valid[0]), 32'd0);
    check("b2b_hold", resp_rdata[0], 32'hA5A5A5A5);

`ifdef DMEM_PARITY_EN
    inject_perr[0] = 1;
    xact(0, 1, 32'h20, 32'h12345678, 4'hF, ar, ae, al);
    inject_perr[0] = 0;
    xact(0, 0, 32'h20, 32'h0, 4'h0, ar, ae, al);
    check("par_bad_err", 32'(ae), 32'd1);
    check("par_bad_data", ar, 32'h12345678);
    xact(0, 1, 32'h20, 32'h12345678, 4'hF, ar, ae, al);
    xact(0, 0, 32'h20, 32'h0, 4'h0, ar, ae, al);
    check("par_ok_err", 32'(ae), 32'd0);
    check("par_ok_data", ar, 32'h12345678);
    model_req(0, 1, 32'h20, 32'h12345678, 4'hF, er, ee, el);
`endif

    // Randomised traffic against the model
    for (int k = 0; k < 2; k++) begin
      for (int w = 0; w < 16; w++)
        checked_req(k, 1, 32'(w * 4), $urandom, 4'hF);
      for (int n = 0; n < 120; n++) begin
        int sel, w;
        logic [31:0] a;
        sel = int'($urandom_range(0, 9));
        w   = int'($urandom_range(0, 15));
        if (sel == 0)      a = 32'(w * 4) + $urandom_range(1, 3);
        else if (sel == 1) a = 32'(w * 4) | (32'h1 << $urandom_range(12, 31));
        else               a = 32'(w * 4);
        checked_req(k, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
      end
    end

    // RD_LAT=3: request held valid for 6 cycles
    for (int c = 0; c < 12; c++) begin
      if (c < 6) rdy[c] = req_ready[1];
      if (resp_valid[1] === 1'b1) got.push_back(resp_rdata[1]);
      req_valid[1] = (c < 6); req_we[1] = 0;
      req_addr[1]  = (c == 0) ? 32'h0 : 32'h10;
      @(negedge clk);
    end
    for (int c = 0; c < 6; c++)
      check($sformatf("tput_ready c%0d", c), 32'(rdy[c]), 32'((c % 3) == 0));
    check("tput_count", 32'(got.size()), 32'd2);
    if (got.size() >= 2) begin
      check("tput_first", got[0], mdl[1][0]);
      check("tput_second", got[1], mdl[1][4]);
    end

    // Reset two cycles into an RD_LAT=4 read; a write coinciding with reset is dropped
    req_valid[2] = 1; req_we[2] = 0; req_addr[2] = 32'h10;
    @(negedge clk);
    req_valid[2] = 0;
    @(negedge clk);
    reset = 1;
    req_valid[0] = 1; req_we[0] = 1; req_addr[0] = 32'h10;
    req_wdata[0] = 32'hFFFFFFFF; req_be[0] = 4'hF;
    @(negedge clk);
    reset = 0;
    req_valid[0] = 0;
    check("rst_mid_ready", 32'(req_ready[2]), 32'd1);
    check("rst_mid_rdata0", resp_rdata[0], 32'h0);
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      if (resp_valid[2] === 1'b1) cnt++;
      @(negedge clk);
    end
    check("rst_mid_no_resp", 32'(cnt), 32'd0);
    xact(0, 0, 32'h10, 32'h0, 4'h0, ar, ae, al);
    check("rst_write_dropped", ar, mdl[0][4]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
